surf_wb_fanout: RTL and testbench

Parametrised Wishbone fan-out from one classic-cycle target port to `NCH` SURF bridge channels, selected per transaction. It is the successor to the fixed 7-way SURF mux: channel count, address width and timeout are generic. Unlike that mux, it latches the channel at cycle start, registers all request and response paths, and rejects invalid or disabled channels itself. Stalled channels are terminated by a watchdog, and a per-channel sticky error flag records each failure. It sits between the TURFIO control-bus crossbar and the per-SURF `rackctl` bridges.

---
 rtl/surf_wb_fanout.sv | 217 +++++++++++++++++++++
 tb/tb_surf_wb_fanout.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_wb_fanout.sv
`default_nettype none
// ============================================================================
//  Module   : surf_wb_fanout
//  Purpose  : Wishbone classic-cycle fan-out from one upstream target port to
//             NCH downstream SURF bridge channels, chosen per transaction by
//             select_i (1..NCH). Channel and request fields are latched at
//             cycle start, all request and response paths are registered,
//             invalid or disabled channels are rejected locally with ERR, and
//             a watchdog terminates stalled channels. Sticky per-channel
//             error / timeout flags record failures.
//  Ports    : wb_clk_i, wb_rst_ni        clock, async active-low reset
//             cyc_i/stb_i/we_i/sel_i/adr_i/dat_i/select_i   upstream request
//             dat_o/ack_o/err_o/rty_o    upstream response
//             m_cyc_o/m_stb_o            per-channel request (one-hot or 0)
//             m_we_o/m_sel_o/m_adr_o/m_dat_o  shared downstream fields
//             m_dat_i/m_ack_i/m_err_i/m_rty_i  per-channel response
//             chan_en_i                  channel enable mask
//             err_rst_i                  clear sticky flags
//             chan_err_o/chan_tmo_o      sticky per-channel flags
//             busy_o                     FSM not idle
//  Revision : 1.0  initial release
// ============================================================================
module surf_wb_fanout #(
    parameter int NCH     = 7,
    parameter int SEL_W   = 4,
    parameter int ADR_W   = 22,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic [31:0]       dat_i,
    input  logic [SEL_W-1:0]  select_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              rty_o,
    output logic [NCH-1:0]    m_cyc_o,
    output logic [NCH-1:0]    m_stb_o,
    output logic              m_we_o,
    output logic [3:0]        m_sel_o,
    output logic [ADR_W-1:0]  m_adr_o,
    output logic [31:0]       m_dat_o,
    input  logic [32*NCH-1:0] m_dat_i,
    input  logic [NCH-1:0]    m_ack_i,
    input  logic [NCH-1:0]    m_err_i,
    input  logic [NCH-1:0]    m_rty_i,
    input  logic [NCH-1:0]    chan_en_i,
    input  logic              err_rst_i,
    output logic [NCH-1:0]    chan_err_o,
    output logic [NCH-1:0]    chan_tmo_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [NCH-1:0]     ch_mask;   // latched channel, one-hot (0 if select invalid)
    logic [NCH-1:0]     req_mask;  // drives m_cyc_o / m_stb_o
    logic [CNT_W-1:0]   cnt;

    logic [NCH-1:0]     sel_mask;
    logic               sel_ok;
    logic               ack_hit, err_hit, rty_hit;
    logic [31:0]        rdata;
    logic               accept, go_req, bad, abort, tmo;
    logic               rsp_ack, rsp_err, rsp_rty;

    assign m_cyc_o = req_mask;
    assign m_stb_o = req_mask;

    // Decode select_i into a one-hot mask; out-of-range values give all zero,
    // which also avoids indexing chan_en_i outside its range.
    always_comb begin
        sel_mask = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (select_i == SEL_W'(k + 1)) begin
                sel_mask[k] = 1'b1;
                sel_ok      = chan_en_i[k];
            end
        end
    end

    // Only the latched channel can terminate; stray responses are masked off.
    always_comb begin
        ack_hit = |(m_ack_i & ch_mask);
        err_hit = |(m_err_i & ch_mask);
        rty_hit = |(m_rty_i & ch_mask);
        rdata   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_mask[k]) begin
                rdata = rdata | m_dat_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        go_req   = 1'b0;
        bad      = 1'b0;
        abort    = 1'b0;
        tmo      = 1'b0;
        rsp_ack  = 1'b0;
        rsp_err  = 1'b0;
        rsp_rty  = 1'b0;
        case (state)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    accept = 1'b1;
                    if (sel_ok) begin
                        go_req   = 1'b1;
                        state_nx = REQ;
                    end else begin
                        bad      = 1'b1;
                        state_nx = RESP;
                    end
                end
            end
            REQ: begin
                // An upstream abort beats any response arriving in the same cycle.
                if (!cyc_i) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else if (ack_hit) begin
                    rsp_ack  = 1'b1;
                    state_nx = RESP;
                end else if (err_hit) begin
                    rsp_err  = 1'b1;
                    state_nx = RESP;
                end else if (rty_hit) begin
                    rsp_rty  = 1'b1;
                    state_nx = RESP;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            ch_mask    <= '0;
            req_mask   <= '0;
            cnt        <= '0;
            m_we_o     <= 1'b0;
            m_sel_o    <= '0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            dat_o      <= '0;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
            rty_o      <= 1'b0;
            busy_o     <= 1'b0;
            chan_err_o <= '0;
            chan_tmo_o <= '0;
        end else begin
            state  <= state_nx;
            busy_o <= (state_nx != IDLE);
            ack_o  <= rsp_ack;
            err_o  <= rsp_err | bad | tmo;
            rty_o  <= rsp_rty;

            if (accept) begin
                ch_mask <= sel_mask;
                m_we_o  <= we_i;
                m_sel_o <= sel_i;
                m_adr_o <= adr_i;
                m_dat_o <= dat_i;
            end

            if (go_req) begin
                req_mask <= sel_mask;
                cnt      <= '0;
            end else if (state == REQ) begin
                if (state_nx != REQ) begin
                    req_mask <= '0;
                end
                // Saturate so a long stall can never wrap back below TIMEOUT.
                if (cnt != CNT_W'(TIMEOUT)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (bad || tmo) begin
                dat_o <= '0;
            end else if (rsp_ack || rsp_err || rsp_rty) begin
                dat_o <= rdata;
            end

            // Set terms are ORed after the clear so a same-cycle event survives.
            chan_err_o <= (err_rst_i ? '0 : chan_err_o) | ((rsp_err || tmo) ? ch_mask : '0);
            chan_tmo_o <= (err_rst_i ? '0 : chan_tmo_o) | (tmo ? ch_mask : '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_surf_wb_fanout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_surf_wb_fanout
//  Purpose  : Self-checking bench for surf_wb_fanout (NCH=7, TIMEOUT=16).
//             Directed transfers with a per-transfer downstream responder;
//             expected upstream responses are queued when a request is
//             driven and compared when the DUT terminates.
//  Revision : 1.0  initial release
// ============================================================================
module tb_surf_wb_fanout;

    localparam int NCH     = 7;
    localparam int SEL_W   = 4;
    localparam int ADR_W   = 22;
    localparam int TIMEOUT = 16;

    localparam int K_ACK = 1;
    localparam int K_ERR = 2;
    localparam int K_RTY = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [ADR_W-1:0]  adr;
    logic [31:0]       dat;
    logic [SEL_W-1:0]  select;
    logic [31:0]       dat_o;
    logic              ack_o, err_o, rty_o;
    logic [NCH-1:0]    m_cyc_o, m_stb_o;
    logic              m_we_o;
    logic [3:0]        m_sel_o;
    logic [ADR_W-1:0]  m_adr_o;
    logic [31:0]       m_dat_o;
    logic [32*NCH-1:0] m_dat_i, bg;
    logic [NCH-1:0]    m_ack, m_err, m_rty;
    logic [NCH-1:0]    chan_en;
    logic              err_rst;
    logic [NCH-1:0]    chan_err_o, chan_tmo_o;
    logic              busy_o;

    typedef struct {
        int          kind;
        logic [31:0] dat;
        bit          chk_dat;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    surf_wb_fanout #(
        .NCH(NCH), .SEL_W(SEL_W), .ADR_W(ADR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .cyc_i     (cyc),
        .stb_i     (stb),
        .we_i      (we),
        .sel_i     (sel),
        .adr_i     (adr),
        .dat_i     (dat),
        .select_i  (select),
        .dat_o     (dat_o),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .rty_o     (rty_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_sel_o   (m_sel_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack),
        .m_err_i   (m_err),
        .m_rty_i   (m_rty),
        .chan_en_i (chan_en),
        .err_rst_i (err_rst),
        .chan_err_o(chan_err_o),
        .chan_tmo_o(chan_tmo_o),
        .busy_o    (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {ack_o, err_o, rty_o, busy_o, m_cyc_o, m_stb_o, chan_err_o, chan_tmo_o}, 64'd0);
        chk({tag, "_fld"}, {m_we_o, m_sel_o, m_adr_o, m_dat_o}, 64'd0);
        chk({tag, "_dat"}, dat_o, 64'd0);
    endtask

    // One upstream transfer. The responder answers on channel ch 'dly' cycles
    // after m_stb_o is first seen; kind 0 means the channel never answers.
    task automatic xfer(input string tag, input int ch, input logic wr,
                        input logic [ADR_W-1:0] a, input logic [31:0] wd,
                        input int dly, input int kind, input logic [31:0] rd,
                        input int stray, input int glitch, input bit clr_on_rsp,
                        input bit down, input exp_t e);
        int          stb_c;
        bit          done;
        bit          bad_cyc;
        logic [6:0]  em;
        logic [3:0]  sv;
        exp_t        x;
        em = down ? (7'b1 << (ch - 1)) : 7'b0;
        sv = wr ? 4'h3 : 4'hF;
        sb.push_back(e);
        select = SEL_W'(ch); we = wr; adr = a; dat = wd; sel = sv;
        cyc = 1'b1; stb = 1'b1;
        stb_c = -1; done = 0; bad_cyc = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk); #1;
            m_ack = '0; m_err = '0; m_rty = '0; m_dat_i = bg; err_rst = 1'b0;
            if ((m_cyc_o & ~em) != 0 || (m_stb_o & ~em) != 0) bad_cyc = 1;
            if (stb_c < 0 && m_stb_o != 0) begin
                stb_c = c;
                chk({tag, "_fields"}, {m_we_o, m_sel_o, m_adr_o, m_dat_o}, {wr, sv, a, wd});
            end
            if (glitch != 0 && c == 2) select = SEL_W'(glitch);
            if (stb_c > 0 && stray != 0 && c == stb_c + 1) m_ack[stray-1] = 1'b1;
            if (stb_c > 0 && kind != 0 && c == stb_c + dly) begin
                if (kind == K_ACK) m_ack[ch-1] = 1'b1;
                if (kind == K_ERR) m_err[ch-1] = 1'b1;
                if (kind == K_RTY) m_rty[ch-1] = 1'b1;
                m_dat_i[(ch-1)*32 +: 32] = rd;
                err_rst = clr_on_rsp;
            end
            if (ack_o || err_o || rty_o) begin
                done = 1;
                x = sb.pop_front();
                chk({tag, "_kind"}, {rty_o, err_o, ack_o}, x.kind);
                chk({tag, "_lat"}, c, x.lat);
                if (x.chk_dat) chk({tag, "_dat"}, dat_o, x.dat);
            end
        end
        m_ack = '0; m_err = '0; m_rty = '0; m_dat_i = bg; err_rst = 1'b0;
        if (!done) begin
            void'(sb.pop_front());
            chk({tag, "_no_response"}, 0, 1);
        end
        chk({tag, "_cyc_onehot"}, bad_cyc, 0);
        if (down) chk({tag, "_req_lat"}, stb_c, 1);
        else      chk({tag, "_no_req"}, stb_c, -1);
        @(posedge clk); #1;
        chk({tag, "_resp_1cyc"}, {rty_o, err_o, ack_o, busy_o, m_cyc_o}, 0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic term;
        for (int k = 0; k < NCH; k++) bg[k*32 +: 32] = 32'hC0DE0000 | k;
        m_dat_i = bg; m_ack = '0; m_err = '0; m_rty = '0;
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; select = 0;
        chan_en = '1; err_rst = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fast read on channel 3
        xfer("read3", 3, 0, 22'h012345, 32'h0, 2, K_ACK, 32'hDEADBEEF, 0, 0, 0, 1,
             '{K_ACK, 32'hDEADBEEF, 1, 4});

        // Invalid and disabled selects
        xfer("sel0", 0, 0, 22'h000100, 32'h0, 0, 0, 0, 0, 0, 0, 0, '{K_ERR, 32'h0, 1, 1});
        xfer("sel8", NCH + 1, 0, 22'h000200, 32'h0, 0, 0, 0, 0, 0, 0, 0, '{K_ERR, 32'h0, 1, 1});
        chan_en = 7'b1111101;
        xfer("dis2", 2, 0, 22'h000300, 32'h0, 1, K_ACK, 32'h1, 0, 0, 0, 0, '{K_ERR, 32'h0, 1, 1});
        chan_en = '1;
        chk("flags_after_invalid", {chan_err_o, chan_tmo_o}, 0);

        // Retry and error responses
        xfer("rty6", 6, 0, 22'h3F0000, 32'h0, 3, K_RTY, 32'h0BADF00D, 0, 0, 0, 1,
             '{K_RTY, 32'h0BADF00D, 1, 5});
        chk("flags_after_rty", {chan_err_o, chan_tmo_o}, 0);
        xfer("err7", 7, 1, 22'h000777, 32'hA5A5A5A5, 1, K_ERR, 32'h55AA55AA, 0, 0, 0, 1,
             '{K_ERR, 32'h55AA55AA, 1, 3});
        chk("flags_after_err7", {chan_err_o, chan_tmo_o}, {7'b1000000, 7'b0000000});
        err_rst = 1'b1;
        @(posedge clk); #1;
        err_rst = 1'b0;
        chk("flags_cleared", {chan_err_o, chan_tmo_o}, 0);

        // Watchdog on channel 5
        xfer("tmo5", 5, 0, 22'h055555, 32'h0, 0, 0, 0, 0, 0, 0, 1,
             '{K_ERR, 32'h0, 0, TIMEOUT + 2});
        chk("flags_after_tmo", {chan_err_o, chan_tmo_o}, {7'b0010000, 7'b0010000});

        // Clear coincident with a new channel-5 err: the err flag survives
        xfer("err5_clr", 5, 0, 22'h055556, 32'h0, 2, K_ERR, 32'h00000555, 0, 0, 1, 1,
             '{K_ERR, 32'h00000555, 1, 4});
        chk("flags_clr_vs_set", {chan_err_o, chan_tmo_o}, {7'b0010000, 7'b0000000});

        // Abort three cycles into REQ
        select = 4'd2; we = 0; sel = 4'hF; adr = 22'h2AAAAA; dat = 0;
        cyc = 1; stb = 1;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_req_up", m_cyc_o, 7'b0000010);
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        chk("abort_cyc_drop", {m_cyc_o, m_stb_o}, 0);
        term = 0;
        repeat (4) begin
            term = term | ack_o | err_o | rty_o;
            @(posedge clk); #1;
        end
        chk("abort_no_term", {term, busy_o}, 0);
        chk("abort_flags", {chan_err_o, chan_tmo_o}, {7'b0010000, 7'b0000000});
        xfer("wr1", 1, 1, 22'h111111, 32'h12345678, 1, K_ACK, 32'h0000AC01, 0, 0, 0, 1,
             '{K_ACK, 32'h0000AC01, 1, 3});

        // Select glitch and stray ack on channel 6: only channel 4 completes
        xfer("glitch4", 4, 0, 22'h044444, 32'h0, 3, K_ACK, 32'hCAFE0004, 6, 6, 0, 1,
             '{K_ACK, 32'hCAFE0004, 1, 5});

        // Asynchronous reset in the middle of REQ
        select = 4'd4; we = 0; sel = 4'hF; adr = 22'h0A0A0A;
        cyc = 1; stb = 1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_pre", m_cyc_o, 7'b0001000);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer("post_rst", 2, 0, 22'h022222, 32'h0, 2, K_ACK, 32'h600DCAFE, 0, 0, 0, 1,
             '{K_ACK, 32'h600DCAFE, 1, 4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
